// File: rtl/data_mem.sv
// Data memory for load/store: DEPTH x DATA_WIDTH words.
// Ports: clk, rst (sync, high), address_bus, data_in, r_w (1=wr), data_out.
module data_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_bus,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_w,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Reset wipes every word and masks any write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_w) begin
      r_mem[address_bus] <= data_in;
    end
  end

  // Asynchronous read: follows the address with no clock latency.
  assign data_out = r_mem[address_bus];

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem.
// Scoreboard queue of expected read values against a local model.
module tb_data_mem;

  logic       clk;
  logic       rst;
  logic [7:0] address_bus;
  logic [7:0] data_in;
  logic       r_w;
  logic [7:0] data_out;

  int checks;
  int failures;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic [7:0] got;
  logic [7:0] exp;

  data_mem dut (
    .clk        (clk),
    .rst        (rst),
    .address_bus(address_bus),
    .data_in    (data_in),
    .r_w        (r_w),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address_bus = a;
    data_in     = d;
    r_w         = 1'b1;
    @(posedge clk);
    #1;
    model[a] = d;
    r_w = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] addrs [3];
    addrs = '{8'd0, 8'd1, 8'd255};
    do_reset();
    foreach (addrs[k]) begin
      @(negedge clk);
      r_w = 1'b0;
      address_bus = addrs[k];
      exp_q.push_back(8'h00);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h",
                 addrs[k], got, exp);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] addrs [2];
    logic [7:0] vals  [2];
    addrs = '{8'd0, 8'd1};
    vals  = '{8'h01, 8'h07};
    do_write(8'd0, 8'h01);
    do_write(8'd1, 8'h07);
    foreach (addrs[k]) begin
      @(negedge clk);
      r_w = 1'b0;
      address_bus = addrs[k];
      exp_q.push_back(vals[k]);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL basic_read addr=%0d got=%h exp=%h",
                 addrs[k], got, exp);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [7:0] nb [2];
    nb = '{8'd4, 8'd6};
    do_write(8'd5, 8'hAA);
    @(negedge clk);
    address_bus = 8'd5;
    data_in     = 8'h55;
    r_w         = 1'b1;
    exp_q.push_back(8'hAA);
    #1;
    got = data_out;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL rdw_before got=%h exp=%h", got, exp);
    end
    @(posedge clk);
    #1;
    model[5] = 8'h55;
    r_w = 1'b0;
    exp_q.push_back(8'h55);
    got = data_out;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL rdw_after got=%h exp=%h", got, exp);
    end
    foreach (nb[k]) begin
      @(negedge clk);
      address_bus = nb[k];
      exp_q.push_back(8'h00);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL overwrite_nb addr=%0d got=%h exp=%h",
                 nb[k], got, exp);
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] addrs [4];
    addrs = '{8'd255, 8'd0, 8'd254, 8'd1};
    do_write(8'd255, 8'hFF);
    do_write(8'd0, 8'h3C);
    foreach (addrs[k]) begin
      @(negedge clk);
      r_w = 1'b0;
      address_bus = addrs[k];
      exp_q.push_back(model[addrs[k]]);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL boundary addr=%0d got=%h exp=%h",
                 addrs[k], got, exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [7:0] addrs [6];
    addrs = '{8'd10, 8'd0, 8'd1, 8'd5, 8'd255, 8'd254};
    @(negedge clk);
    rst         = 1'b1;
    r_w         = 1'b1;
    address_bus = 8'd10;
    data_in     = 8'h77;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rst = 1'b0;
    r_w = 1'b0;
    foreach (addrs[k]) begin
      @(negedge clk);
      address_bus = addrs[k];
      exp_q.push_back(8'h00);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rst_prio addr=%0d got=%h exp=%h",
                 addrs[k], got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    // Consecutive write edges with no idle cycle between them.
    @(negedge clk);
    for (int n = 0; n < 64; n++) begin
      a = 8'($urandom_range(0, 255));
      address_bus = a;
      data_in     = 8'($urandom);
      r_w         = 1'b1;
      @(posedge clk);
      #1;
      model[a] = data_in;
      @(negedge clk);
    end
    r_w = 1'b0;
    for (int i = 0; i < 256; i++) begin
      address_bus = 8'(i);
      exp_q.push_back(model[i]);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_read addr=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_read_only();
    logic [7:0] a;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      a = 8'($urandom_range(0, 255));
      r_w         = 1'b0;
      address_bus = a;
      data_in     = ~data_in;
      exp_q.push_back(model[a]);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL read_only addr=%0d got=%h exp=%h", a, got, exp);
      end
      @(posedge clk);
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      address_bus = 8'(i);
      exp_q.push_back(model[i]);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL read_only_sweep addr=%0d got=%h exp=%h",
                 i, got, exp);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    r_w         = 1'b0;
    address_bus = 8'd0;
    data_in     = 8'h00;
    test_reset();
    test_basic();
    test_overwrite();
    test_boundary();
    test_reset_priority();
    test_back_to_back();
    test_read_only();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
